serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl_if.sv | 13 +
 rtl/serial_adder_ctrl.sv | 72 +++++++
 tb/tb_serial_adder_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: handshake and operand/result bundle for the serial adder
interface serial_adder_ctrl_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial a+b+cin, LSB first, one bit per clock through one full-adder cell
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                rst,
    serial_adder_ctrl_if.slave io_bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           r_state;
    logic [WIDTH-1:0] r_a, r_b, r_res, r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry, r_cout, r_busy, r_done;
    logic             w_p, w_g, w_s, w_cnext;
    logic [WIDTH-1:0] w_res_next;
    assign w_p        = r_a[0] ^ r_b[0];
    assign w_g        = r_a[0] & r_b[0];
    assign w_s        = w_p ^ r_carry;
    assign w_cnext    = w_g | (w_p & r_carry);
    assign w_res_next = {w_s, {(WIDTH-1){1'b0}}} | (r_res >> 1);
    assign io_bus.busy = r_busy;
    assign io_bus.done = r_done;
    assign io_bus.sum  = r_sum;
    assign io_bus.cout = r_cout;
    // Controller and datapath: capture in IDLE, one sum bit per RUN cycle, publish result entering DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (io_bus.start) begin
                    r_a     <= io_bus.a;
                    r_b     <= io_bus.b;
                    r_carry <= io_bus.cin;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                    r_state <= RUN;
                end
                RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_res   <= w_res_next;
                    r_carry <= w_cnext;
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_sum   <= w_res_next;
                        r_cout  <= w_cnext;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed and random checks of the serial adder, WIDTH=8
module tb_serial_adder_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    serial_adder_ctrl_if #(.WIDTH(8)) bus ();
    serial_adder_ctrl #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .io_bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept one addition, optionally pulse start with new operands on RUN cycle inj, check timing and result
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                          input logic [8:0] exp, input int inj);
        int n;
        @(negedge clk);
        bus.a = ta; bus.b = tb; bus.cin = tc; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.a = ~ta; bus.b = ~tb; bus.cin = ~tc;
        n = 0;
        while (bus.busy && n < 20) begin
            chk("busy_done_excl", bus.done, 1'b0);
            n++;
            if (n == inj) begin
                bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55; bus.cin = 1'b1;
            end else bus.start = 1'b0;
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("busy_len", n, 8);
        chk("done_pulse", bus.done, 1'b1);
        chk("sum", bus.sum, exp[7:0]);
        chk("cout", bus.cout, exp[8]);
        @(negedge clk);
        chk("done_clear", bus.done, 1'b0);
        chk("busy_after", bus.busy, 1'b0);
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rc;
        int         pulses;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_sum", bus.sum, 8'h00);
        chk("rst_cout", bus.cout, 1'b0);
        rst = 1'b0;

        run_op(8'h0F, 8'h01, 1'b0, 9'h010, -1);
        run_op(8'hFF, 8'h01, 1'b0, 9'h100, -1);
        run_op(8'hFF, 8'hFF, 1'b1, 9'h1FF, -1);

        run_op(8'h12, 8'h34, 1'b0, 9'h046, 3);
        repeat (3) begin
            @(negedge clk);
            chk("no_restart", bus.busy, 1'b0);
        end

        @(negedge clk);
        bus.a = 8'h0F; bus.b = 8'h01; bus.cin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_abort_busy", bus.busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_done", bus.done, 1'b0);
        chk("abort_sum", bus.sum, 8'h00);
        chk("abort_cout", bus.cout, 1'b0);
        repeat (8) begin
            @(negedge clk);
            chk("abort_no_done", bus.done, 1'b0);
        end
        run_op(8'h55, 8'hAA, 1'b0, 9'h0FF, -1);

        @(negedge clk);
        rst = 1'b1; bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h01;
        @(negedge clk);
        rst = 1'b0; bus.start = 1'b0;
        chk("rst_prio_busy", bus.busy, 1'b0);

        @(negedge clk);
        bus.a = 8'h30; bus.b = 8'h0C; bus.cin = 1'b1; bus.start = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                bus.a = 8'h01; bus.b = 8'h01; bus.cin = 1'b0;
            end
            if (i == 20) bus.start = 1'b0;
            if (bus.done) pulses++;
            chk($sformatf("held_done_%0d", i), bus.done, (i == 9 || i == 19));
            if (i >= 9) chk($sformatf("held_sum_%0d", i), {bus.cout, bus.sum}, (i < 19) ? 9'h03D : 9'h002);
        end
        chk("held_pulses", pulses, 2);
        repeat (3) @(negedge clk);

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            run_op(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {8'h00, rc}, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
